// File: rtl/pwu_mt_pkg.sv
// Shared types, default parameter values and helpers for the multi-walker page-walk unit.
// The optional checker stage is controlled by the PWU_MT_CHECKER_EN macro.
package pwu_mt_pkg;

  localparam int unsigned NUM_WALKERS_D = 4;
  localparam int unsigned VA_W_D        = 32;
  localparam int unsigned PA_W_D        = 28;
  localparam int unsigned PAGE_OFF_W_D  = 12;
  localparam int unsigned IDX_W_D       = 10;
  localparam int unsigned PWC_W_D       = 16;
  localparam int unsigned PTE_W_D       = 32;

  typedef enum logic [2:0] {
    W_IDLE,
    W_PWC_REQ,
    W_PWC_WAIT,
    W_L1_REQ,
    W_L1_WAIT,
    W_CH_REQ,
    W_CH_WAIT,
    W_DONE
  } walker_state_e;

  // Bits of a PTE above the physical frame number; any of them set means a fault.
  function automatic logic [63:0] pte_fault_mask(input int unsigned pte_w,
                                                 input int unsigned pfn_w);
    logic [63:0] m;
    m = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      if (i >= pfn_w && i < pte_w) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/pwu_mt_walker.sv
// One page-walk FSM: holds the VA, PW-cache table base, frame number and fault flag.
// Checker states and ports exist only with PWU_MT_CHECKER_EN.
module pwu_mt_walker
  import pwu_mt_pkg::*;
#(
  parameter int unsigned TAG_W      = 2,
  parameter int unsigned MY_TAG     = 0,
  parameter int unsigned VA_W       = VA_W_D,
  parameter int unsigned PA_W       = PA_W_D,
  parameter int unsigned PAGE_OFF_W = PAGE_OFF_W_D,
  parameter int unsigned PWC_W      = PWC_W_D,
  parameter int unsigned PTE_W      = PTE_W_D
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 i_alloc,
  input  logic [VA_W-1:0]      i_va,
  input  logic                 i_pwc_hs,
  input  logic                 i_pwc_rsp_vld,
  input  logic [TAG_W-1:0]     i_pwc_rsp_tag,
  input  logic                 i_pwc_rsp_hit,
  input  logic [PWC_W-1:0]     i_pwc_rsp_data,
  input  logic                 i_l1_hs,
  input  logic                 i_l1_rsp_vld,
  input  logic [TAG_W-1:0]     i_l1_rsp_tag,
  input  logic [PTE_W-1:0]     i_l1_rsp_data,
`ifdef PWU_MT_CHECKER_EN
  input  logic                 i_ch_hs,
  input  logic                 i_ch_rsp_vld,
  input  logic [TAG_W-1:0]     i_ch_rsp_tag,
  input  logic                 i_ch_rsp_fault,
`endif
  input  logic                 i_retire,
  output walker_state_e        o_state,
  output logic [VA_W-1:0]      o_va,
  output logic [PWC_W-1:0]     o_pwc_data,
  output logic [PA_W-1:0]      o_pa,
  output logic                 o_fault
);

  localparam int unsigned PFN_W = PA_W - PAGE_OFF_W;
  localparam logic [63:0] MASK64 = pte_fault_mask(PTE_W, PFN_W);
  localparam logic [PTE_W-1:0] FAULT_MASK = MASK64[PTE_W-1:0];

  walker_state_e      r_state;
  logic [VA_W-1:0]    r_va;
  logic [PWC_W-1:0]   r_pwc_data;
  logic [PFN_W-1:0]   r_pfn;
  logic               r_fault;

  logic w_pwc_mine;
  logic w_l1_mine;
  assign w_pwc_mine = i_pwc_rsp_vld && (i_pwc_rsp_tag == TAG_W'(MY_TAG));
  assign w_l1_mine  = i_l1_rsp_vld  && (i_l1_rsp_tag  == TAG_W'(MY_TAG));
`ifdef PWU_MT_CHECKER_EN
  logic w_ch_mine;
  assign w_ch_mine  = i_ch_rsp_vld  && (i_ch_rsp_tag  == TAG_W'(MY_TAG));
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= W_IDLE;
      r_va       <= '0;
      r_pwc_data <= '0;
      r_pfn      <= '0;
      r_fault    <= 1'b0;
    end else begin
      case (r_state)
        W_IDLE: if (i_alloc) begin
          r_va    <= i_va;
          r_pfn   <= '0;
          r_fault <= 1'b0;
          r_state <= W_PWC_REQ;
        end
        W_PWC_REQ: if (i_pwc_hs) r_state <= W_PWC_WAIT;
        W_PWC_WAIT: if (w_pwc_mine) begin
          // A miss finishes the walk immediately with a fault, skipping L1 and checker.
          if (i_pwc_rsp_hit) begin
            r_pwc_data <= i_pwc_rsp_data;
            r_state    <= W_L1_REQ;
          end else begin
            r_fault    <= 1'b1;
            r_state    <= W_DONE;
          end
        end
        W_L1_REQ: if (i_l1_hs) r_state <= W_L1_WAIT;
        W_L1_WAIT: if (w_l1_mine) begin
          r_pfn   <= i_l1_rsp_data[PFN_W-1:0];
          r_fault <= |(i_l1_rsp_data & FAULT_MASK);
`ifdef PWU_MT_CHECKER_EN
          r_state <= W_CH_REQ;
`else
          r_state <= W_DONE;
`endif
        end
`ifdef PWU_MT_CHECKER_EN
        W_CH_REQ: if (i_ch_hs) r_state <= W_CH_WAIT;
        W_CH_WAIT: if (w_ch_mine) begin
          r_fault <= r_fault | i_ch_rsp_fault;
          r_state <= W_DONE;
        end
`endif
        W_DONE: if (i_retire) r_state <= W_IDLE;
        default: r_state <= W_IDLE;
      endcase
    end
  end

  assign o_state    = r_state;
  assign o_va       = r_va;
  assign o_pwc_data = r_pwc_data;
  assign o_pa       = {r_pfn, r_va[PAGE_OFF_W-1:0]};
  assign o_fault    = r_fault;

endmodule

// File: rtl/pwu_mt.sv
// Multi-walker page-walk unit: ring of walkers, oldest-first locked arbiters, in-order retire.
// Define PWU_MT_CHECKER_EN to add the checker stage and its ports.
module pwu_mt
  import pwu_mt_pkg::*;
#(
  parameter int unsigned NUM_WALKERS = NUM_WALKERS_D,
  parameter int unsigned VA_W        = VA_W_D,
  parameter int unsigned PA_W        = PA_W_D,
  parameter int unsigned PAGE_OFF_W  = PAGE_OFF_W_D,
  parameter int unsigned IDX_W       = IDX_W_D,
  parameter int unsigned PWC_W       = PWC_W_D,
  parameter int unsigned PTE_W       = PTE_W_D,
  localparam int unsigned TAG_W      = $clog2(NUM_WALKERS)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [VA_W-1:0]            va_i,
  input  logic                       va_vld_i,
  output logic                       va_rdy_o,
  output logic [VA_W-PAGE_OFF_W-1:0] pwc_req_vpn_o,
  output logic [TAG_W-1:0]           pwc_req_tag_o,
  output logic                       pwc_req_vld_o,
  input  logic                       pwc_req_rdy_i,
  input  logic [PWC_W-1:0]           pwc_rsp_data_i,
  input  logic                       pwc_rsp_hit_i,
  input  logic [TAG_W-1:0]           pwc_rsp_tag_i,
  input  logic                       pwc_rsp_vld_i,
  output logic [PWC_W+IDX_W-1:0]     l1_req_addr_o,
  output logic [TAG_W-1:0]           l1_req_tag_o,
  output logic                       l1_req_vld_o,
  input  logic                       l1_req_rdy_i,
  input  logic [PTE_W-1:0]           l1_rsp_data_i,
  input  logic [TAG_W-1:0]           l1_rsp_tag_i,
  input  logic                       l1_rsp_vld_i,
`ifdef PWU_MT_CHECKER_EN
  output logic [PA_W-1:0]            ch_req_pa_o,
  output logic [TAG_W-1:0]           ch_req_tag_o,
  output logic                       ch_req_vld_o,
  input  logic                       ch_req_rdy_i,
  input  logic                       ch_rsp_fault_i,
  input  logic [TAG_W-1:0]           ch_rsp_tag_i,
  input  logic                       ch_rsp_vld_i,
`endif
  output logic [PA_W-1:0]            pa_o,
  output logic                       pa_fault_o,
  output logic                       pa_vld_o,
  input  logic                       pa_rdy_i
);

  logic [TAG_W-1:0] r_alloc_ptr, r_ret_ptr;
  logic             r_pwc_lock, r_l1_lock;
  logic [TAG_W-1:0] r_pwc_lock_tag, r_l1_lock_tag;

  walker_state_e    w_state    [NUM_WALKERS];
  logic [VA_W-1:0]  w_va       [NUM_WALKERS];
  logic [PWC_W-1:0] w_pwc_data [NUM_WALKERS];
  logic [PA_W-1:0]  w_pa       [NUM_WALKERS];
  logic             w_fault    [NUM_WALKERS];

  logic [NUM_WALKERS-1:0] w_pwc_reqv, w_l1_reqv, w_alloc_v, w_retire_v, w_pwc_hs_v, w_l1_hs_v;
  logic [TAG_W:0]   w_pwc_pick, w_l1_pick;
  logic [TAG_W-1:0] w_pwc_gnt, w_l1_gnt;
  logic             w_pwc_vld, w_l1_vld, w_pwc_hs, w_l1_hs, w_va_acc, w_pa_hs;

  // Scans from youngest to oldest so the last hit is the walker closest to ret_ptr.
  function automatic logic [TAG_W:0] pick_oldest(input logic [NUM_WALKERS-1:0] req,
                                                 input logic [TAG_W-1:0] base);
    logic [TAG_W:0]   res;
    logic [TAG_W-1:0] idx;
    res = '0;
    for (int unsigned k = NUM_WALKERS; k > 0; k--) begin
      idx = base + TAG_W'(k - 1);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign w_pwc_pick = pick_oldest(w_pwc_reqv, r_ret_ptr);
  assign w_pwc_gnt  = r_pwc_lock ? r_pwc_lock_tag : w_pwc_pick[TAG_W-1:0];
  assign w_pwc_vld  = r_pwc_lock | w_pwc_pick[TAG_W];
  assign w_pwc_hs   = w_pwc_vld & pwc_req_rdy_i;

  assign w_l1_pick  = pick_oldest(w_l1_reqv, r_ret_ptr);
  assign w_l1_gnt   = r_l1_lock ? r_l1_lock_tag : w_l1_pick[TAG_W-1:0];
  assign w_l1_vld   = r_l1_lock | w_l1_pick[TAG_W];
  assign w_l1_hs    = w_l1_vld & l1_req_rdy_i;

  assign va_rdy_o   = (w_state[r_alloc_ptr] == W_IDLE);
  assign w_va_acc   = va_vld_i & va_rdy_o;
  assign pa_vld_o   = (w_state[r_ret_ptr] == W_DONE);
  assign w_pa_hs    = pa_vld_o & pa_rdy_i;

`ifdef PWU_MT_CHECKER_EN
  logic [NUM_WALKERS-1:0] w_ch_reqv, w_ch_hs_v;
  logic                   r_ch_lock;
  logic [TAG_W-1:0]       r_ch_lock_tag, w_ch_gnt;
  logic [TAG_W:0]         w_ch_pick;
  logic                   w_ch_vld, w_ch_hs;

  assign w_ch_pick = pick_oldest(w_ch_reqv, r_ret_ptr);
  assign w_ch_gnt  = r_ch_lock ? r_ch_lock_tag : w_ch_pick[TAG_W-1:0];
  assign w_ch_vld  = r_ch_lock | w_ch_pick[TAG_W];
  assign w_ch_hs   = w_ch_vld & ch_req_rdy_i;

  always_comb begin
    w_ch_reqv = '0;
    w_ch_hs_v = '0;
    for (int unsigned i = 0; i < NUM_WALKERS; i++) begin
      w_ch_reqv[i] = (w_state[i] == W_CH_REQ);
      w_ch_hs_v[i] = w_ch_hs && (w_ch_gnt == TAG_W'(i));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ch_lock     <= 1'b0;
      r_ch_lock_tag <= '0;
    end else if (w_ch_hs) begin
      r_ch_lock     <= 1'b0;
    end else if (w_ch_vld) begin
      r_ch_lock     <= 1'b1;
      r_ch_lock_tag <= w_ch_gnt;
    end
  end

  assign ch_req_vld_o = w_ch_vld;
  assign ch_req_tag_o = w_ch_vld ? w_ch_gnt : '0;
  assign ch_req_pa_o  = w_ch_vld ? w_pa[w_ch_gnt] : '0;
`endif

  always_comb begin
    w_pwc_reqv = '0;
    w_l1_reqv  = '0;
    w_alloc_v  = '0;
    w_retire_v = '0;
    w_pwc_hs_v = '0;
    w_l1_hs_v  = '0;
    for (int unsigned i = 0; i < NUM_WALKERS; i++) begin
      w_pwc_reqv[i] = (w_state[i] == W_PWC_REQ);
      w_l1_reqv[i]  = (w_state[i] == W_L1_REQ);
      w_alloc_v[i]  = w_va_acc && (r_alloc_ptr == TAG_W'(i));
      w_retire_v[i] = w_pa_hs  && (r_ret_ptr   == TAG_W'(i));
      w_pwc_hs_v[i] = w_pwc_hs && (w_pwc_gnt   == TAG_W'(i));
      w_l1_hs_v[i]  = w_l1_hs  && (w_l1_gnt    == TAG_W'(i));
    end
  end

  // A request shown with rdy low pins the grant until its handshake.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_alloc_ptr    <= '0;
      r_ret_ptr      <= '0;
      r_pwc_lock     <= 1'b0;
      r_pwc_lock_tag <= '0;
      r_l1_lock      <= 1'b0;
      r_l1_lock_tag  <= '0;
    end else begin
      if (w_va_acc) r_alloc_ptr <= r_alloc_ptr + TAG_W'(1);
      if (w_pa_hs)  r_ret_ptr   <= r_ret_ptr + TAG_W'(1);
      if (w_pwc_hs) begin
        r_pwc_lock     <= 1'b0;
      end else if (w_pwc_vld) begin
        r_pwc_lock     <= 1'b1;
        r_pwc_lock_tag <= w_pwc_gnt;
      end
      if (w_l1_hs) begin
        r_l1_lock      <= 1'b0;
      end else if (w_l1_vld) begin
        r_l1_lock      <= 1'b1;
        r_l1_lock_tag  <= w_l1_gnt;
      end
    end
  end

  for (genvar g = 0; g < NUM_WALKERS; g++) begin : g_walker
    pwu_mt_walker #(
      .TAG_W      (TAG_W),
      .MY_TAG     (g),
      .VA_W       (VA_W),
      .PA_W       (PA_W),
      .PAGE_OFF_W (PAGE_OFF_W),
      .PWC_W      (PWC_W),
      .PTE_W      (PTE_W)
    ) u_walker (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .i_alloc        (w_alloc_v[g]),
      .i_va           (va_i),
      .i_pwc_hs       (w_pwc_hs_v[g]),
      .i_pwc_rsp_vld  (pwc_rsp_vld_i),
      .i_pwc_rsp_tag  (pwc_rsp_tag_i),
      .i_pwc_rsp_hit  (pwc_rsp_hit_i),
      .i_pwc_rsp_data (pwc_rsp_data_i),
      .i_l1_hs        (w_l1_hs_v[g]),
      .i_l1_rsp_vld   (l1_rsp_vld_i),
      .i_l1_rsp_tag   (l1_rsp_tag_i),
      .i_l1_rsp_data  (l1_rsp_data_i),
`ifdef PWU_MT_CHECKER_EN
      .i_ch_hs        (w_ch_hs_v[g]),
      .i_ch_rsp_vld   (ch_rsp_vld_i),
      .i_ch_rsp_tag   (ch_rsp_tag_i),
      .i_ch_rsp_fault (ch_rsp_fault_i),
`endif
      .i_retire       (w_retire_v[g]),
      .o_state        (w_state[g]),
      .o_va           (w_va[g]),
      .o_pwc_data     (w_pwc_data[g]),
      .o_pa           (w_pa[g]),
      .o_fault        (w_fault[g])
    );
  end

  assign pwc_req_vld_o = w_pwc_vld;
  assign pwc_req_tag_o = w_pwc_vld ? w_pwc_gnt : '0;
  assign pwc_req_vpn_o = w_pwc_vld ? w_va[w_pwc_gnt][VA_W-1:PAGE_OFF_W] : '0;
  assign l1_req_vld_o  = w_l1_vld;
  assign l1_req_tag_o  = w_l1_vld ? w_l1_gnt : '0;
  assign l1_req_addr_o = w_l1_vld ? {w_pwc_data[w_l1_gnt], w_va[w_l1_gnt][PAGE_OFF_W +: IDX_W]} : '0;
  assign pa_o          = pa_vld_o ? w_pa[r_ret_ptr] : '0;
  assign pa_fault_o    = pa_vld_o ? w_fault[r_ret_ptr] : 1'b0;

endmodule
